tube_tdc_event_builder: RTL

Parametrised drift-tube TDC event builder: on a scintillator-coincidence trigger it opens a fixed timing window and timestamps the first rising edge of each tube channel. When the window closes it serialises the event into a header word plus per-channel hit words, and places them in an output FIFO with a valid/ready handshake toward the RPi readout. It replaces per-tube edge-clocked capture with fully synchronous logic in the single `clk100` domain.

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_sync_edge.sv | 30 +++
 rtl/tube_tdc_event_builder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the drift-tube TDC event builder.
package tdc_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWindow = 2'd1,
    StDrain  = 2'd2
  } tdc_state_e;

  localparam logic HDR_TAG = 1'b1;
  localparam logic HIT_TAG = 1'b0;

  // All-ones sentinel for a channel with no hit; sliced to TW bits by users.
  localparam logic [127:0] TIME_NONE = '1;

  function automatic int calc_ch_w(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  function automatic int calc_out_w(input int nch, input int tw);
    return 1 + calc_ch_w(nch) + tw;
  endfunction

endpackage

// File: rtl/tdc_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module tdc_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_async;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/tube_tdc_event_builder.sv
// Drift-tube TDC event builder: trigger window, first-edge capture, serialised FIFO output.
// Optional zero suppression of no-hit channels via `TDC_ZERO_SUPPRESS_EN.
module tube_tdc_event_builder
  import tdc_pkg::*;
#(
  parameter int NCH   = 32,
  parameter int TW    = 8,
  parameter int WIN   = 32,
  parameter int DEPTH = 64,
  localparam int CH_W  = calc_ch_w(NCH),
  localparam int OUT_W = calc_out_w(NCH, TW)
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic [NCH-1:0]   tube_in,
  input  logic             scin_coin,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0]   WIN_LAST = TW'(WIN - 1);
  localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NCH - 1);
  localparam logic [TW-1:0]   T_NONE   = TIME_NONE[TW-1:0];

  logic [NCH-1:0] w_tube_pulse;
  logic           w_trig;

  for (genvar g = 0; g < NCH; g++) begin : g_tube
    tdc_sync_edge u_sync (
      .i_clk   (clk100),
      .i_rst   (rst),
      .i_async (tube_in[g]),
      .o_pulse (w_tube_pulse[g])
    );
  end

  tdc_sync_edge u_trig_sync (
    .i_clk   (clk100),
    .i_rst   (rst),
    .i_async (scin_coin),
    .o_pulse (w_trig)
  );

  tdc_state_e       r_state;
  logic [TW-1:0]    r_cntr;
  logic [NCH-1:0]   r_hit;
  logic [TW-1:0]    r_time [NCH];
  logic             r_hdr_phase;
  logic [CH_W-1:0]  r_idx;
  logic [OUT_W-2:0] r_evt_num;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic             w_full;
  logic             w_wr_en;
  logic [OUT_W-1:0] w_wr_data;
  logic             w_pop;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && out_ready;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    if (r_state == StDrain) begin
      if (r_hdr_phase) begin
        w_wr_en   = !w_full;
        w_wr_data = {HDR_TAG, r_evt_num};
      end else begin
`ifdef TDC_ZERO_SUPPRESS_EN
        w_wr_en   = !w_full && r_hit[r_idx];
`else
        w_wr_en   = !w_full;
`endif
        w_wr_data = {HIT_TAG, r_idx, r_time[r_idx]};
      end
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cntr      <= '0;
      r_hit       <= '0;
      r_hdr_phase <= 1'b1;
      r_idx       <= '0;
      r_evt_num   <= '0;
      for (int i = 0; i < NCH; i++) r_time[i] <= T_NONE;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_trig) begin
            r_state <= StWindow;
            r_cntr  <= '0;
            r_hit   <= '0;
            for (int i = 0; i < NCH; i++) r_time[i] <= T_NONE;
          end
        end
        StWindow: begin
          r_cntr <= r_cntr + 1'b1;
          for (int i = 0; i < NCH; i++) begin
            if (w_tube_pulse[i] && !r_hit[i]) begin
              r_time[i] <= r_cntr;
              r_hit[i]  <= 1'b1;
            end
          end
          if (r_cntr == WIN_LAST) begin
            r_state     <= StDrain;
            r_hdr_phase <= 1'b1;
            r_idx       <= '0;
          end
        end
        StDrain: begin
          // A full FIFO freezes the walk so no word is skipped.
          if (!w_full) begin
            if (r_hdr_phase) begin
              r_hdr_phase <= 1'b0;
            end else if (r_idx == IDX_LAST) begin
              r_state   <= StIdle;
              r_evt_num <= r_evt_num + 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_trig && (r_state != StIdle)) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (w_wr_en) r_mem[r_wptr] <= w_wr_data;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = r_mem[r_rptr];
  assign out_valid = (r_count != '0);
  assign busy      = (r_state != StIdle);
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
